// File: rtl/mem_loader_pkg.sv
// Shared definitions for the byte-stream RAM loader and the RAM it drives:
// default bus widths and the loader state encoding.
package mem_loader_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;
    localparam int BYTE_W     = 8;

    typedef enum logic [2:0] {
        IDLE,
        LO,
        HI,
        WRITE,
        RD,
        RDW,
        DONE
    } state_t;

endpackage

// File: rtl/mem_loader_byte_packer.sv
// Assembles two stream bytes into one RAM word, low byte first; each half
// updates on the edge its enable is high. No latency beyond that edge; no backpressure.
module byte_packer
    import mem_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BYTE_W-1:0]     byte_in,
    input  logic                  lo_en,
    input  logic                  hi_en,
    output logic [2*BYTE_W-1:0]   word
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
        end else begin
            if (lo_en) word[BYTE_W-1:0]        <= byte_in;
            if (hi_en) word[2*BYTE_W-1:BYTE_W] <= byte_in;
        end
    end

endmodule

// File: rtl/mem_loader.sv
// Loads a byte stream into a dual-port RAM as 16-bit words, and serves single reads.
// 3 cycles/word, load of n words ends 3n+1 cycles after start; read data 2 cycles after rd_req; byte_ready only in LO/HI.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] word_cnt,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] mem_dat_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              wr,
    output logic              rd,
    output logic              init,
    input  logic [DATA_W-1:0] mem_dat_out,
    output logic              busy,
    output logic              done
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic [ADDR_W-1:0] last, last_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic              lo_en, hi_en;
    logic [15:0]       word;

    byte_packer u_packer (
        .clk     (clk),
        .rst_n   (rst_n),
        .byte_in (byte_in),
        .lo_en   (lo_en),
        .hi_en   (hi_en),
        .word    (word)
    );

    assign mem_dat_in = DATA_W'(word);
    assign rd_data    = mem_dat_out;

    always_comb begin
        state_nxt    = state;
        addr_nxt     = addr;
        last_nxt     = last;
        mem_addr_nxt = mem_addr;
        lo_en        = 1'b0;
        hi_en        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LO;
                    addr_nxt  = '0;
                    last_nxt  = word_cnt;
                end else if (rd_req) begin
                    state_nxt    = RD;
                    mem_addr_nxt = rd_addr;
                end
            end
            LO: begin
                if (byte_valid) begin
                    lo_en     = 1'b1;
                    state_nxt = HI;
                end
            end
            HI: begin
                if (byte_valid) begin
                    hi_en        = 1'b1;
                    mem_addr_nxt = addr;
                    state_nxt    = WRITE;
                end
            end
            WRITE: begin
                // Stop on the last word rather than incrementing, so 255 never wraps to 0.
                if (addr == last) begin
                    state_nxt = DONE;
                end else begin
                    addr_nxt  = addr + ADDR_W'(1);
                    state_nxt = LO;
                end
            end
            RD:      state_nxt = RDW;
            RDW:     state_nxt = IDLE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they align with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr       <= '0;
            last       <= '0;
            mem_addr   <= '0;
            wr         <= 1'b0;
            rd         <= 1'b0;
            init       <= 1'b0;
            byte_ready <= 1'b0;
            rd_valid   <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            addr       <= addr_nxt;
            last       <= last_nxt;
            mem_addr   <= mem_addr_nxt;
            wr         <= (state_nxt == WRITE);
            rd         <= (state_nxt == RD);
            init       <= (state_nxt == WRITE) || (state_nxt == RD);
            byte_ready <= (state_nxt == LO) || (state_nxt == HI);
            rd_valid   <= (state_nxt == RDW);
            done       <= (state_nxt == DONE);
            busy       <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader with a behavioural dual-port RAM (registered read).
module tb_mem_loader;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk, rst_n, start, byte_valid, byte_ready, rd_req, rd_valid;
    logic          wr, rd, init, busy, done;
    logic [AW-1:0] word_cnt, rd_addr, mem_addr;
    logic [7:0]    byte_in;
    logic [DW-1:0] rd_data, mem_dat_in, mem_dat_out;

    mem_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .word_cnt    (word_cnt),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .mem_dat_in  (mem_dat_in),
        .mem_addr    (mem_addr),
        .wr          (wr),
        .rd          (rd),
        .init        (init),
        .mem_dat_out (mem_dat_out),
        .busy        (busy),
        .done        (done)
    );

    logic [DW-1:0] ram [0:255];
    int            wr_cnt, wr0_cnt, rd_cnt, done_cnt, viol, ready_err;
    logic [AW-1:0] last_wr;
    int            pass_cnt, chk_cnt;
    logic [7:0]    byte_q [$];

    typedef struct {
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [7:0]  addr;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs [3];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (wr) begin
            ram[mem_addr] <= mem_dat_in;
            wr_cnt        <= wr_cnt + 1;
            last_wr       <= mem_addr;
            if (mem_addr == 8'h00) wr0_cnt <= wr0_cnt + 1;
        end
        if (rd) begin
            mem_dat_out <= ram[mem_addr];
            rd_cnt      <= rd_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
        if ((wr && rd) || (init !== (wr | rd))) viol <= viol + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pat_word(input int w);
        logic [7:0] lo, hi;
        lo = 8'((2 * w) * 7 + 3);
        hi = 8'((2 * w + 1) * 7 + 3);
        return {hi, lo};
    endfunction

    // Feeds byte_q into the loader; returns the cycle (start cycle = 0) on which done is seen.
    task automatic run_load(input int n, input bit gap, input bit noise, input int abort_at,
                            input bit issue_start, input int budget, output int done_at);
        int idx;
        bit acc;
        idx     = 0;
        done_at = -1;
        if (issue_start) begin
            word_cnt = AW'(n - 1);
            start    = 1'b1;
            rd_req   = noise;
            tick();
            start  = 1'b0;
            rd_req = 1'b0;
        end
        for (int cyc = 1; cyc <= budget; cyc++) begin
            if (done) begin
                done_at = cyc;
                break;
            end
            if (abort_at >= 0 && wr && int'(mem_addr) == abort_at) break;
            if (wr && byte_ready) ready_err++;
            if (noise) begin
                start    = 1'($urandom_range(0, 1));
                rd_req   = 1'($urandom_range(0, 1));
                word_cnt = AW'($urandom_range(0, 255));
                rd_addr  = AW'($urandom_range(0, 255));
            end
            byte_valid = (idx < byte_q.size()) && (!gap || (cyc % 2 == 0));
            byte_in    = (idx < byte_q.size()) ? byte_q[idx] : 8'h00;
            acc        = byte_valid && byte_ready;
            tick();
            if (acc) idx++;
        end
        byte_valid = 1'b0;
        start      = 1'b0;
        rd_req     = 1'b0;
        if (done_at < 0 && abort_at < 0) begin
            chk_cnt++;
            $display("FAIL load_timeout: no done within %0d cycles", budget);
        end
    endtask

    initial begin
        int done_at, w0, z0, r0, d0;

        rst_n = 1'b1; start = 1'b0; word_cnt = '0; byte_in = '0;
        byte_valid = 1'b0; rd_req = 1'b0; rd_addr = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy",       32'(busy), 0);
        chk("rst_done",       32'(done), 0);
        chk("rst_byte_ready", 32'(byte_ready), 0);
        chk("rst_rd_valid",   32'(rd_valid), 0);
        chk("rst_wr",         32'(wr), 0);
        chk("rst_rd",         32'(rd), 0);
        chk("rst_init",       32'(init), 0);
        chk("rst_mem_addr",   32'(mem_addr), 0);
        chk("rst_mem_dat_in", 32'(mem_dat_in), 0);
        @(posedge clk);
        tick();
        rst_n = 1'b1;

        vecs[0] = '{lo: 8'h34, hi: 8'h12, addr: 8'h00, exp: 16'h1234};
        vecs[1] = '{lo: 8'h78, hi: 8'h56, addr: 8'h01, exp: 16'h5678};
        vecs[2] = '{lo: 8'hBC, hi: 8'h9A, addr: 8'h02, exp: 16'h9ABC};

        // Basic three-word load
        byte_q = {};
        foreach (vecs[i]) begin
            byte_q.push_back(vecs[i].lo);
            byte_q.push_back(vecs[i].hi);
        end
        w0 = wr_cnt; d0 = done_cnt;
        run_load(3, 1'b0, 1'b0, -1, 1'b1, 40, done_at);
        tick();
        chk("load_done_cycle", 32'(done_at), 10);
        chk("load_writes",     32'(wr_cnt - w0), 3);
        chk("load_done_pulse", 32'(done_cnt - d0), 1);
        foreach (vecs[i]) chk("load_ram", 32'(ram[vecs[i].addr]), 32'(vecs[i].exp));

        // Reads: rd strobe one cycle after request, data one cycle later
        foreach (vecs[i]) begin
            rd_req  = 1'b1;
            rd_addr = vecs[i].addr;
            tick();
            rd_req = 1'b0;
            chk("rd_strobe",     32'(rd), 1);
            chk("rd_mem_addr",   32'(mem_addr), 32'(vecs[i].addr));
            chk("rd_valid_early", 32'(rd_valid), 0);
            tick();
            chk("rd_valid",      32'(rd_valid), 1);
            chk("rd_data",       32'(rd_data), 32'(vecs[i].exp));
            tick();
            chk("rd_valid_pulse", 32'(rd_valid), 0);
        end

        // start and rd_req together, then random start/rd_req noise while busy
        byte_q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        r0 = rd_cnt; d0 = done_cnt;
        run_load(3, 1'b0, 1'b1, -1, 1'b1, 40, done_at);
        tick();
        chk("noise_done_cycle", 32'(done_at), 10);
        chk("noise_no_rd",      32'(rd_cnt - r0), 0);
        chk("noise_done_pulse", 32'(done_cnt - d0), 1);
        chk("noise_ram0", 32'(ram[0]), 32'h2211);
        chk("noise_ram1", 32'(ram[1]), 32'h4433);
        chk("noise_ram2", 32'(ram[2]), 32'h6655);

        // Gapped byte stream rewrites the original contents
        byte_q = {};
        foreach (vecs[i]) begin
            byte_q.push_back(vecs[i].lo);
            byte_q.push_back(vecs[i].hi);
        end
        ready_err = 0;
        run_load(3, 1'b1, 1'b0, -1, 1'b1, 80, done_at);
        tick();
        chk("gap_done_cycle", 32'(done_at), 14);
        chk("gap_ready_in_write", 32'(ready_err), 0);
        foreach (vecs[i]) chk("gap_ram", 32'(ram[vecs[i].addr]), 32'(vecs[i].exp));

        // Full 256-word load
        byte_q = {};
        for (int k = 0; k < 512; k++) byte_q.push_back(8'(k * 7 + 3));
        w0 = wr_cnt; z0 = wr0_cnt; d0 = done_cnt;
        run_load(256, 1'b0, 1'b0, -1, 1'b1, 900, done_at);
        tick();
        tick();
        chk("full_done_cycle", 32'(done_at), 769);
        chk("full_writes",     32'(wr_cnt - w0), 256);
        chk("full_addr0_once", 32'(wr0_cnt - z0), 1);
        chk("full_last_addr",  32'(last_wr), 32'hFF);
        chk("full_done_pulse", 32'(done_cnt - d0), 1);
        chk("full_ram00", 32'(ram[0]),   32'(pat_word(0)));
        chk("full_ram80", 32'(ram[128]), 32'(pat_word(128)));
        chk("full_ramFF", 32'(ram[255]), 32'(pat_word(255)));

        // Reset during the third word's write cycle
        byte_q = {8'hA1, 8'hA2, 8'hB1, 8'hB2, 8'hC1, 8'hC2, 8'hD1, 8'hD2};
        w0 = wr_cnt; d0 = done_cnt;
        run_load(4, 1'b0, 1'b0, 2, 1'b1, 40, done_at);
        chk("abort_reached_write", 32'(wr), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_wr",         32'(wr), 0);
        chk("abort_busy",       32'(busy), 0);
        chk("abort_init",       32'(init), 0);
        chk("abort_byte_ready", 32'(byte_ready), 0);
        tick();
        tick();
        tick();
        chk("abort_writes",  32'(wr_cnt - w0), 2);
        chk("abort_no_done", 32'(done_cnt - d0), 0);
        chk("abort_ram0", 32'(ram[0]), 32'hA2A1);
        chk("abort_ram1", 32'(ram[1]), 32'hB2B1);
        chk("abort_ram2", 32'(ram[2]), 32'(pat_word(2)));

        // start on the first edge after reset release
        rst_n    = 1'b1;
        start    = 1'b1;
        word_cnt = '0;
        byte_q   = {8'h55, 8'h66};
        d0 = done_cnt;
        tick();
        start = 1'b0;
        chk("restart_busy",       32'(busy), 1);
        chk("restart_byte_ready", 32'(byte_ready), 1);
        run_load(1, 1'b0, 1'b0, -1, 1'b0, 20, done_at);
        tick();
        chk("restart_done_cycle", 32'(done_at), 4);
        chk("restart_done_pulse", 32'(done_cnt - d0), 1);
        chk("restart_ram0", 32'(ram[0]), 32'h6655);

        chk("strobe_rules", 32'(viol), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
